// File: rtl/adc_value_monitor_pkg.sv
// Shared definitions for the ADC value monitor: register map, sizes and helpers.
package adc_value_monitor_pkg;

  localparam int unsigned NumCh = 32;
  localparam int unsigned DataW = 12;

  // Word addresses on the 16-bit Wishbone bus. _1 is the upper half-word, _0 the lower.
  localparam logic [15:0] REG_AVM_VALUE_BASE    = 16'h0000;
  localparam logic [15:0] REG_AVM_HI_BASE       = 16'h0020;
  localparam logic [15:0] REG_AVM_LO_BASE       = 16'h0040;
  localparam logic [15:0] REG_AVM_ALARM_OVER_1  = 16'h0060;
  localparam logic [15:0] REG_AVM_ALARM_OVER_0  = 16'h0061;
  localparam logic [15:0] REG_AVM_ALARM_UNDER_1 = 16'h0062;
  localparam logic [15:0] REG_AVM_ALARM_UNDER_0 = 16'h0063;
  localparam logic [15:0] REG_AVM_IRQ_MASK_1    = 16'h0064;
  localparam logic [15:0] REG_AVM_IRQ_MASK_0    = 16'h0065;
  localparam logic [15:0] REG_AVM_STATUS        = 16'h0066;

  // Coarse address region, decoded from adr[15:5].
  typedef enum logic [1:0] {
    RegionValue,
    RegionHi,
    RegionLo,
    RegionMisc
  } region_e;

  // Bits needed to hold values 0..n-1, never less than one.
  function automatic int unsigned log2_up(input int unsigned n);
    int unsigned r;
    r = 1;
    while ((32'd1 << r) < n) begin
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/avm_threshold_cmp.sv
// S1 compare for one sample: threshold test, debounce counter update and alarm direction.
module avm_threshold_cmp
  import adc_value_monitor_pkg::*;
#(
  parameter int unsigned FAULT_COUNT = 3,
  parameter int unsigned CntW        = 2
) (
  input  logic [DataW-1:0] result,
  input  logic [DataW-1:0] hi,
  input  logic [DataW-1:0] lo,
  input  logic [CntW-1:0]  cnt,
  output logic [CntW-1:0]  cnt_next,
  output logic             set_over,
  output logic             set_under
);

  localparam logic [CntW-1:0] CntMax = CntW'(FAULT_COUNT);

  logic over;
  logic under;

  // Over takes priority so an inverted window (lo > hi) never reports both directions.
  always_comb begin
    over      = result > hi;
    under     = !over && (result < lo);
    cnt_next  = '0;
    set_over  = 1'b0;
    set_under = 1'b0;
    if (over || under) begin
      cnt_next = (cnt >= CntMax) ? CntMax : cnt + CntW'(1);
      // Saturated count keeps re-arming the alarm for every further fault.
      if (cnt_next == CntMax) begin
        set_over  = over;
        set_under = under;
      end
    end
  end

endmodule

// File: rtl/adc_value_monitor.sv
// Latest-value store, debounced threshold alarms and interrupt for 32 ADC channels.
module adc_value_monitor
  import adc_value_monitor_pkg::*;
#(
  parameter int unsigned      FAULT_COUNT = 3,
  parameter logic [DataW-1:0] DEFAULT_HI  = 12'hFFF,
  parameter logic [DataW-1:0] DEFAULT_LO  = 12'h000
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             wb_stb_i,
  input  logic             wb_cyc_i,
  input  logic             wb_we_i,
  input  logic [15:0]      wb_adr_i,
  input  logic [15:0]      wb_dat_i,
  output logic [15:0]      wb_dat_o,
  output logic             wb_ack_o,
  input  logic             adc_strb,
  input  logic [4:0]       adc_channel,
  input  logic [DataW-1:0] adc_result,
  output logic             irq,
  output logic             alarm_any
);

  localparam int unsigned CntW = log2_up(FAULT_COUNT + 1);

  logic [DataW-1:0] values [NumCh];
  logic [DataW-1:0] hi     [NumCh];
  logic [DataW-1:0] lo     [NumCh];
  logic [CntW-1:0]  cnt    [NumCh];

  logic [31:0] alarm_over;
  logic [31:0] alarm_under;
  logic [31:0] irq_mask;
  logic [15:0] sample_count;

  logic             s1_valid;
  logic [4:0]       s1_ch;
  logic [DataW-1:0] s1_res;

  logic [CntW-1:0] cnt_next;
  logic            set_over;
  logic            set_under;

  region_e     region;
  logic [4:0]  adr_ch;
  logic        bus_acc;
  logic        bus_wr;
  logic        hi_wr;
  logic        lo_wr;
  logic        status_wr;
  logic [31:0] clr_over;
  logic [31:0] clr_under;
  logic [31:0] set_over_vec;
  logic [31:0] set_under_vec;
  logic [15:0] rdata;

  avm_threshold_cmp #(
    .FAULT_COUNT(FAULT_COUNT),
    .CntW       (CntW)
  ) u_cmp (
    .result   (s1_res),
    .hi       (hi[s1_ch]),
    .lo       (lo[s1_ch]),
    .cnt      (cnt[s1_ch]),
    .cnt_next (cnt_next),
    .set_over (set_over),
    .set_under(set_under)
  );

  // Bus decode: one access per ack, write strobes and W1C masks.
  always_comb begin
    adr_ch    = wb_adr_i[4:0];
    bus_acc   = wb_cyc_i && wb_stb_i && !wb_ack_o;
    bus_wr    = bus_acc && wb_we_i;
    region    = RegionMisc;
    if (wb_adr_i[15:5] == REG_AVM_VALUE_BASE[15:5]) region = RegionValue;
    else if (wb_adr_i[15:5] == REG_AVM_HI_BASE[15:5]) region = RegionHi;
    else if (wb_adr_i[15:5] == REG_AVM_LO_BASE[15:5]) region = RegionLo;
    hi_wr     = bus_wr && (region == RegionHi);
    lo_wr     = bus_wr && (region == RegionLo);
    status_wr = bus_wr && (wb_adr_i == REG_AVM_STATUS);
    clr_over  = '0;
    clr_under = '0;
    if (bus_wr && wb_adr_i == REG_AVM_ALARM_OVER_1)  clr_over[31:16]  = wb_dat_i;
    if (bus_wr && wb_adr_i == REG_AVM_ALARM_OVER_0)  clr_over[15:0]   = wb_dat_i;
    if (bus_wr && wb_adr_i == REG_AVM_ALARM_UNDER_1) clr_under[31:16] = wb_dat_i;
    if (bus_wr && wb_adr_i == REG_AVM_ALARM_UNDER_0) clr_under[15:0]  = wb_dat_i;
  end

  // Read mux over the current (pre-update) register contents.
  always_comb begin
    rdata = '0;
    unique case (region)
      RegionValue: rdata = {4'b0, values[adr_ch]};
      RegionHi:    rdata = {4'b0, hi[adr_ch]};
      RegionLo:    rdata = {4'b0, lo[adr_ch]};
      RegionMisc: begin
        case (wb_adr_i)
          REG_AVM_ALARM_OVER_1:  rdata = alarm_over[31:16];
          REG_AVM_ALARM_OVER_0:  rdata = alarm_over[15:0];
          REG_AVM_ALARM_UNDER_1: rdata = alarm_under[31:16];
          REG_AVM_ALARM_UNDER_0: rdata = alarm_under[15:0];
          REG_AVM_IRQ_MASK_1:    rdata = irq_mask[31:16];
          REG_AVM_IRQ_MASK_0:    rdata = irq_mask[15:0];
          REG_AVM_STATUS:        rdata = sample_count;
          default:               rdata = '0;
        endcase
      end
      default: rdata = '0;
    endcase
  end

  // Alarm set vectors from the sample currently in S1.
  always_comb begin
    set_over_vec  = '0;
    set_under_vec = '0;
    if (s1_valid) begin
      set_over_vec[s1_ch]  = set_over;
      set_under_vec[s1_ch] = set_under;
    end
  end

  // S0 -> S1 sample capture; reset discards any in-flight sample.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      s1_valid <= 1'b0;
      s1_ch    <= '0;
      s1_res   <= '0;
    end else begin
      s1_valid <= adc_strb;
      s1_ch    <= adc_channel;
      s1_res   <= adc_result;
    end
  end

  // Per-channel storage. Later statements win: threshold writes and status writes clear
  // counters after the pipeline update, so the compare always uses the old threshold.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      for (int i = 0; i < NumCh; i++) begin
        values[i] <= '0;
        hi[i]     <= DEFAULT_HI;
        lo[i]     <= DEFAULT_LO;
        cnt[i]    <= '0;
      end
      sample_count <= '0;
    end else begin
      if (s1_valid) begin
        values[s1_ch] <= s1_res;
        cnt[s1_ch]    <= cnt_next;
        sample_count  <= sample_count + 16'd1;
      end
      if (hi_wr) begin
        hi[adr_ch]  <= wb_dat_i[DataW-1:0];
        cnt[adr_ch] <= '0;
      end
      if (lo_wr) begin
        lo[adr_ch]  <= wb_dat_i[DataW-1:0];
        cnt[adr_ch] <= '0;
      end
      if (status_wr) begin
        for (int i = 0; i < NumCh; i++) cnt[i] <= '0;
      end
    end
  end

  // Sticky alarms: pipeline set beats W1C; a status write clears everything.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      alarm_over  <= '0;
      alarm_under <= '0;
    end else if (status_wr) begin
      alarm_over  <= '0;
      alarm_under <= '0;
    end else begin
      alarm_over  <= (alarm_over & ~clr_over) | set_over_vec;
      alarm_under <= (alarm_under & ~clr_under) | set_under_vec;
    end
  end

  // Wishbone ack, registered read data, mask register and interrupt.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
      irq_mask <= '0;
      irq      <= 1'b0;
    end else begin
      wb_ack_o <= wb_cyc_i && wb_stb_i && !wb_ack_o;
      if (bus_acc) wb_dat_o <= rdata;
      if (bus_wr && wb_adr_i == REG_AVM_IRQ_MASK_1) irq_mask[31:16] <= wb_dat_i;
      if (bus_wr && wb_adr_i == REG_AVM_IRQ_MASK_0) irq_mask[15:0]  <= wb_dat_i;
      irq <= |((alarm_over | alarm_under) & irq_mask);
    end
  end

  assign alarm_any = |(alarm_over | alarm_under);

endmodule

// File: tb/tb_adc_value_monitor.sv
// Bench for adc_value_monitor: directed scenarios plus randomized traffic against a model.
module tb_adc_value_monitor;

  localparam int FC = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stb = 1'b0;
  logic        cyc = 1'b0;
  logic        we  = 1'b0;
  logic [15:0] adr = '0;
  logic [15:0] dat = '0;
  logic [15:0] dat_o;
  logic        ack;
  logic        strb = 1'b0;
  logic [4:0]  ch   = '0;
  logic [11:0] res  = '0;
  logic        irq;
  logic        alarm_any;

  int errors = 0;
  int checks = 0;
  logic chk_en = 1'b0;

  adc_value_monitor #(
    .FAULT_COUNT(FC),
    .DEFAULT_HI (12'hFFF),
    .DEFAULT_LO (12'h000)
  ) dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .wb_stb_i   (stb),
    .wb_cyc_i   (cyc),
    .wb_we_i    (we),
    .wb_adr_i   (adr),
    .wb_dat_i   (dat),
    .wb_dat_o   (dat_o),
    .wb_ack_o   (ack),
    .adc_strb   (strb),
    .adc_channel(ch),
    .adc_result (res),
    .irq        (irq),
    .alarm_any  (alarm_any)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Debounce is tracked as an unbounded run length of consecutive out-of-range samples.
  logic [11:0] m_val [32];
  logic [11:0] m_hi  [32];
  logic [11:0] m_lo  [32];
  int          m_run [32];
  logic [31:0] m_over, m_under, m_mask;
  logic [15:0] m_cnt, m_rdata;
  logic        m_ack, m_irq;
  logic        p_valid;
  int          p_ch;
  logic [11:0] p_res;

  function automatic logic [15:0] model_read(input logic [15:0] a);
    if (a < 16'h20) return {4'b0, m_val[a[4:0]]};
    if (a < 16'h40) return {4'b0, m_hi[a[4:0]]};
    if (a < 16'h60) return {4'b0, m_lo[a[4:0]]};
    case (a)
      16'h60: return m_over[31:16];
      16'h61: return m_over[15:0];
      16'h62: return m_under[31:16];
      16'h63: return m_under[15:0];
      16'h64: return m_mask[31:16];
      16'h65: return m_mask[15:0];
      16'h66: return m_cnt;
      default: return 16'h0000;
    endcase
  endfunction

  always @(posedge clk) begin
    logic [31:0] old_any, setv_o, setv_u, clr_o, clr_u;
    logic acc, wr, ov, un;
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        m_val[i] = '0; m_hi[i] = 12'hFFF; m_lo[i] = 12'h000; m_run[i] = 0;
      end
      m_over = '0; m_under = '0; m_mask = '0; m_cnt = '0;
      m_rdata = '0; m_ack = 1'b0; m_irq = 1'b0; p_valid = 1'b0;
    end else begin
      old_any = (m_over | m_under) & m_mask;
      acc = cyc && stb && !m_ack;
      wr  = acc && we;
      if (acc) m_rdata = model_read(adr);
      setv_o = '0; setv_u = '0;
      if (p_valid) begin
        ov = p_res > m_hi[p_ch];
        un = !ov && (p_res < m_lo[p_ch]);
        m_val[p_ch] = p_res;
        m_cnt = m_cnt + 16'd1;
        if (ov || un) begin
          m_run[p_ch]++;
          if (m_run[p_ch] >= FC) begin
            if (ov) setv_o[p_ch] = 1'b1;
            else setv_u[p_ch] = 1'b1;
          end
        end else begin
          m_run[p_ch] = 0;
        end
      end
      clr_o = '0; clr_u = '0;
      if (wr) begin
        if (adr >= 16'h20 && adr < 16'h40) begin m_hi[adr[4:0]] = dat[11:0]; m_run[adr[4:0]] = 0; end
        if (adr >= 16'h40 && adr < 16'h60) begin m_lo[adr[4:0]] = dat[11:0]; m_run[adr[4:0]] = 0; end
        if (adr == 16'h60) clr_o[31:16] = dat;
        if (adr == 16'h61) clr_o[15:0]  = dat;
        if (adr == 16'h62) clr_u[31:16] = dat;
        if (adr == 16'h63) clr_u[15:0]  = dat;
        if (adr == 16'h64) m_mask[31:16] = dat;
        if (adr == 16'h65) m_mask[15:0]  = dat;
      end
      m_over  = (m_over & ~clr_o) | setv_o;
      m_under = (m_under & ~clr_u) | setv_u;
      if (wr && adr == 16'h66) begin
        m_over = '0; m_under = '0;
        for (int i = 0; i < 32; i++) m_run[i] = 0;
      end
      m_irq   = |old_any;
      m_ack   = cyc && stb && !m_ack;
      p_valid = strb;
      p_ch    = int'(ch);
      p_res   = res;
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("ack", {31'b0, ack}, {31'b0, m_ack});
      check("rdata", {16'b0, dat_o}, {16'b0, m_rdata});
      check("irq", {31'b0, irq}, {31'b0, m_irq});
      check("alarm_any", {31'b0, alarm_any}, {31'b0, |(m_over | m_under)});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = a; dat = d;
    tick();
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    tick();
  endtask

  task automatic bus_read(input logic [15:0] a, input logic [15:0] exp, input string name);
    logic [15:0] got;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = a;
    tick();
    got = dat_o;
    cyc = 1'b0; stb = 1'b0;
    tick();
    check(name, {16'b0, got}, {16'b0, exp});
  endtask

  task automatic send_sample(input logic [4:0] c, input logic [11:0] v);
    strb = 1'b1; ch = c; res = v;
    tick();
    strb = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int kind;
    logic busy;
    tick(); tick(); tick();
    chk_en = 1'b1;
    rst = 1'b0;
    tick();

    // 1: reset values and plain in-range samples
    bus_read(16'h0020, 16'h0FFF, "hi0_reset");
    bus_read(16'h0040, 16'h0000, "lo0_reset");
    bus_read(16'h0060, 16'h0000, "over_reset");
    check("irq_reset", {31'b0, irq}, 32'd0);
    repeat (3) send_sample(5'd5, 12'h800);
    tick();
    check("no_alarm_ch5", {31'b0, alarm_any}, 32'd0);
    bus_read(16'h0005, 16'h0800, "value5");
    bus_read(16'h0066, 16'h0003, "count3");

    // 2: over alarm after three consecutive faults, irq one cycle later
    bus_write(16'h0022, 16'h0400);
    bus_write(16'h0065, 16'h0004);
    send_sample(5'd2, 12'h500);
    send_sample(5'd2, 12'h500);
    tick();
    check("ch2_two_faults", {31'b0, alarm_any}, 32'd0);
    send_sample(5'd2, 12'h500);
    check("ch2_n1", {31'b0, alarm_any}, 32'd0);
    tick();
    check("ch2_alarm_n2", {31'b0, alarm_any}, 32'd1);
    check("ch2_irq_n2", {31'b0, irq}, 32'd0);
    tick();
    check("ch2_irq_n3", {31'b0, irq}, 32'd1);
    bus_read(16'h0061, 16'h0004, "over_lo_ch2");

    // 3: debounce broken by an in-range sample
    bus_write(16'h0047, 16'h0100);
    send_sample(5'd7, 12'h080);
    send_sample(5'd7, 12'h080);
    send_sample(5'd7, 12'h200);
    send_sample(5'd7, 12'h080);
    send_sample(5'd7, 12'h080);
    tick();
    bus_read(16'h0063, 16'h0000, "under_debounce");
    send_sample(5'd7, 12'h080);
    tick();
    bus_read(16'h0063, 16'h0080, "under_ch7");

    // 4: W1C racing a pipeline re-set, then a clean clear
    strb = 1'b1; ch = 5'd2; res = 12'h500;
    tick();
    strb = 1'b0;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 16'h0061; dat = 16'h0004;
    tick();
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    tick();
    bus_read(16'h0061, 16'h0004, "w1c_race");
    bus_write(16'h0061, 16'h0004);
    bus_read(16'h0061, 16'h0000, "w1c_clear");
    check("irq_dropped", {31'b0, irq}, 32'd0);

    // 5: inverted window, over wins
    bus_write(16'h0049, 16'h0300);
    bus_write(16'h0029, 16'h0200);
    repeat (FC) send_sample(5'd9, 12'h250);
    tick();
    bus_read(16'h0061, 16'h0200, "over_ch9");
    bus_read(16'h0063, 16'h0080, "under_not_ch9");

    // 6: back-to-back samples, then reset with a sample in S1
    strb = 1'b1; ch = 5'd0; res = 12'h111;
    tick();
    ch = 5'd1; res = 12'h222;
    tick();
    strb = 1'b0;
    tick();
    bus_read(16'h0000, 16'h0111, "b2b_ch0");
    bus_read(16'h0001, 16'h0222, "b2b_ch1");
    bus_read(16'h0066, 16'h0012, "count18");
    bus_read(16'h0070, 16'h0000, "unmapped");
    strb = 1'b1; ch = 5'd3; res = 12'hABC;
    tick();
    strb = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    bus_read(16'h0003, 16'h0000, "rst_discard_val");
    bus_read(16'h0066, 16'h0000, "rst_discard_cnt");

    // Randomized traffic, checked every cycle by the model.
    bus_write(16'h0065, 16'h000F);
    busy = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      strb = ($urandom % 10) < 6;
      ch   = ($urandom % 8 == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 3));
      res  = 12'($urandom_range(0, 4095));
      if (!busy && ($urandom % 4 == 0)) begin
        cyc = 1'b1; stb = 1'b1; busy = 1'b1;
        kind = $urandom % 10;
        we = 1'b1;
        dat = 16'($urandom);
        case (kind)
          0: adr = 16'h0020 + 16'($urandom_range(0, 3));
          1: adr = 16'h0040 + 16'($urandom_range(0, 3));
          2: adr = 16'h0060 + 16'($urandom_range(0, 3));
          3: adr = 16'h0064 + 16'($urandom_range(0, 1));
          4: begin
            adr = ($urandom % 4 == 0) ? 16'h0066 : 16'h0070;
          end
          default: begin
            we  = 1'b0;
            adr = ($urandom % 8 == 0) ? 16'($urandom) : 16'($urandom_range(0, 16'h6F));
          end
        endcase
      end else begin
        cyc = 1'b0; stb = 1'b0; we = 1'b0; busy = 1'b0;
      end
      rst = ($urandom % 700 == 0);
      tick();
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0; strb = 1'b0; rst = 1'b0;
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
